// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants, line/frame total helpers and the coordinate type
// shared by the VGA sync generator and its axis counters.
package vga_timing_pkg;

    localparam int unsigned DefHDisplay = 640;
    localparam int unsigned DefHFront   = 16;
    localparam int unsigned DefHSync    = 96;
    localparam int unsigned DefHBack    = 48;
    localparam int unsigned DefVDisplay = 480;
    localparam int unsigned DefVFront   = 10;
    localparam int unsigned DefVSync    = 2;
    localparam int unsigned DefVBack    = 33;

    // Largest total that a coord_t counter can still cover (0..CoordLimit-1).
    localparam int unsigned CoordLimit  = 1024;

    typedef logic [9:0] coord_t;

    function automatic int unsigned h_total(input int unsigned display, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return display + front + sync + back;
    endfunction

    function automatic int unsigned v_total(input int unsigned display, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return display + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus decode of the sync and display windows
// for the position the counter holds after the current edge.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned DISPLAY = DefHDisplay,
    parameter int unsigned FRONT   = DefHFront,
    parameter int unsigned SYNC    = DefHSync,
    parameter int unsigned BACK    = DefHBack,
    parameter bit          POL     = 1'b0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   step_i,
    output coord_t count_o,
    output logic   wrap_o,
    output logic   in_sync_o,
    output logic   in_display_o
);

    typedef logic [10:0] wide_t;

    localparam int unsigned Total     = h_total(DISPLAY, FRONT, SYNC, BACK);
    localparam coord_t      LastCount = coord_t'(Total - 1);
    localparam wide_t       SyncStart = wide_t'(DISPLAY + FRONT);
    localparam wide_t       SyncEnd   = wide_t'(DISPLAY + FRONT + SYNC);
    localparam wide_t       DispEnd   = wide_t'(DISPLAY);

    coord_t count_q, count_d;
    wide_t  count_ext;
    logic   at_last;

    assign at_last = (count_q == LastCount);
    assign wrap_o  = step_i && at_last;
    assign count_o = count_q;

    // Windows are decoded from the next count so the parent can register them in step
    // with the counter itself.
    always_comb begin
        count_d = count_q;
        if (step_i) begin
            count_d = at_last ? '0 : count_q + coord_t'(1);
        end
        count_ext    = {1'b0, count_d};
        in_sync_o    = (count_ext >= SyncStart) && (count_ext < SyncEnd);
        in_display_o = (count_ext < DispEnd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: counters, registered sync/display decode, line/frame pulses.
// Define VGA_SYNC_GEN_ALIGN_EN to delay hsync/vsync/display_on by one extra en-step.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY = DefHDisplay,
    parameter int unsigned H_FRONT   = DefHFront,
    parameter int unsigned H_SYNC    = DefHSync,
    parameter int unsigned H_BACK    = DefHBack,
    parameter int unsigned V_DISPLAY = DefVDisplay,
    parameter int unsigned V_FRONT   = DefVFront,
    parameter int unsigned V_SYNC    = DefVSync,
    parameter int unsigned V_BACK    = DefVBack,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned HTotal = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned VTotal = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    if (HTotal > CoordLimit) begin : g_h_total_err
        $error("vga_sync_gen: horizontal total exceeds 10-bit coordinate range");
    end
    if (VTotal > CoordLimit) begin : g_v_total_err
        $error("vga_sync_gen: vertical total exceeds 10-bit coordinate range");
    end

    coord_t h_count, v_count;
    logic   h_wrap, v_wrap;
    logic   h_in_sync, v_in_sync, h_in_display, v_in_display;

    vga_axis_counter #(
        .DISPLAY (H_DISPLAY),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .POL     (HSYNC_POL)
    ) u_h_axis (
        .clk          (clk),
        .rst          (rst),
        .step_i       (en),
        .count_o      (h_count),
        .wrap_o       (h_wrap),
        .in_sync_o    (h_in_sync),
        .in_display_o (h_in_display)
    );

    // Vertical axis only moves on the horizontal wrap, so vsync changes with vpos there.
    vga_axis_counter #(
        .DISPLAY (V_DISPLAY),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .POL     (VSYNC_POL)
    ) u_v_axis (
        .clk          (clk),
        .rst          (rst),
        .step_i       (h_wrap),
        .count_o      (v_count),
        .wrap_o       (v_wrap),
        .in_sync_o    (v_in_sync),
        .in_display_o (v_in_display)
    );

    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       display_q, display_d;
    logic       line_start_q, frame_start_q;
    logic [7:0] frame_count_q, frame_count_d;

    always_comb begin
        hsync_d       = h_in_sync ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = v_in_sync ? VSYNC_POL : ~VSYNC_POL;
        display_d     = h_in_display && v_in_display;
        frame_count_d = frame_count_q + (v_wrap ? 8'd1 : 8'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            display_q     <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_q     <= display_d;
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
            frame_count_q <= frame_count_d;
        end
    end

`ifdef VGA_SYNC_GEN_ALIGN_EN
    logic hsync_al_q, vsync_al_q, display_al_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_al_q   <= ~HSYNC_POL;
            vsync_al_q   <= ~VSYNC_POL;
            display_al_q <= 1'b1;
        end else if (en) begin
            hsync_al_q   <= hsync_q;
            vsync_al_q   <= vsync_q;
            display_al_q <= display_q;
        end
    end

    assign hsync      = hsync_al_q;
    assign vsync      = vsync_al_q;
    assign display_on = display_al_q;
`else
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign display_on = display_q;
`endif

    assign hpos        = h_count;
    assign vpos        = v_count;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: DUT A has 640-wide lines with a short 8-line frame, DUT B is the 7x6 raster.
`timescale 1ns/1ps
module tb_vga_sync_gen;

`ifdef VGA_SYNC_GEN_ALIGN_EN
    localparam bit Align = 1'b1;
`else
    localparam bit Align = 1'b0;
`endif

    logic clk;
    logic rst_a, en_a, rst_b, en_b;
    logic [9:0] hpos_a, vpos_a, hpos_b, vpos_b;
    logic hsync_a, vsync_a, disp_a, ls_a, fs_a;
    logic hsync_b, vsync_b, disp_b, ls_b, fs_b;
    logic [7:0] fc_a, fc_b;

    int pass_cnt = 0;
    int total_cnt = 0;
    // Reference position of DUT A, previous position (for the aligned decode), frame count.
    int eh, ev, ph, pv, efc;
    logic wrapped_l, wrapped_f;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    vga_sync_gen #(
        .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
    ) u_dut_a (
        .clk (clk), .rst (rst_a), .en (en_a),
        .hpos (hpos_a), .vpos (vpos_a), .hsync (hsync_a), .vsync (vsync_a),
        .display_on (disp_a), .line_start (ls_a), .frame_start (fs_a), .frame_count (fc_a)
    );

    vga_sync_gen #(
        .H_DISPLAY (4), .H_FRONT (1), .H_SYNC (1), .H_BACK (1),
        .V_DISPLAY (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
    ) u_dut_b (
        .clk (clk), .rst (rst_b), .en (en_b),
        .hpos (hpos_b), .vpos (vpos_b), .hsync (hsync_b), .vsync (vsync_b),
        .display_on (disp_b), .line_start (ls_b), .frame_start (fs_b), .frame_count (fc_b)
    );

    function automatic logic hs_a(input int h);
        return !((h >= 656) && (h < 752));
    endfunction
    function automatic logic vs_a(input int v);
        return !((v >= 5) && (v < 7));
    endfunction
    function automatic logic dp_a(input int h, input int v);
        return (h < 640) && (v < 4);
    endfunction

    task automatic model_reset();
        eh = 0; ev = 0; ph = 0; pv = 0; efc = 0;
        wrapped_l = 1'b0; wrapped_f = 1'b0;
    endtask

    task automatic tick_a(input logic en_v);
        en_a = en_v;
        @(posedge clk);
        #1;
        wrapped_l = 1'b0;
        wrapped_f = 1'b0;
        if (en_v) begin
            ph = eh; pv = ev;
            if (eh == 799) begin
                eh = 0; wrapped_l = 1'b1;
                if (ev == 7) begin
                    ev = 0; wrapped_f = 1'b1; efc = (efc + 1) % 256;
                end else begin
                    ev = ev + 1;
                end
            end else begin
                eh = eh + 1;
            end
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1; en_a = 1'b1; rst_b = 1'b1; en_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        if ({hpos_a, vpos_a} !== 20'd0) $display("FAIL reset_pos got %0d,%0d want 0,0", hpos_a, vpos_a);
        else pass_cnt++;
        total_cnt++;
        if ({hsync_a, vsync_a} !== 2'b11) $display("FAIL reset_sync got %b%b want 11", hsync_a, vsync_a);
        else pass_cnt++;
        total_cnt++;
        if (disp_a !== 1'b1) $display("FAIL reset_display got %b want 1", disp_a);
        else pass_cnt++;
        total_cnt++;
        if ({ls_a, fs_a} !== 2'b00) $display("FAIL reset_pulses got %b%b want 00", ls_a, fs_a);
        else pass_cnt++;
        total_cnt++;
        if (fc_a !== 8'd0) $display("FAIL reset_frame_count got %0d want 0", fc_a);
        else pass_cnt++;
        total_cnt++;
        if ({hpos_b, hsync_b, disp_b} !== 12'b0000000000_11)
            $display("FAIL reset_small got h=%0d hs=%b de=%b want h=0 hs=1 de=1", hpos_b, hsync_b, disp_b);
        else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_line_timing();
        int ls_seen = 0;
        rst_a = 1'b0;
        for (int i = 0; i < 1600; i++) begin
            tick_a(1'b1);
            if (ls_a) ls_seen++;
            if ({hpos_a, vpos_a} !== {10'(eh), 10'(ev)})
                $display("FAIL line_pos got %0d,%0d want %0d,%0d", hpos_a, vpos_a, eh, ev);
            else pass_cnt++;
            total_cnt++;
            if (hsync_a !== (Align ? hs_a(ph) : hs_a(eh)))
                $display("FAIL line_hsync at h=%0d got %b want %b", eh, hsync_a, ~hsync_a);
            else pass_cnt++;
            total_cnt++;
            if (disp_a !== (Align ? dp_a(ph, pv) : dp_a(eh, ev)))
                $display("FAIL line_display at h=%0d got %b want %b", eh, disp_a, ~disp_a);
            else pass_cnt++;
            total_cnt++;
            if (ls_a !== wrapped_l)
                $display("FAIL line_start at h=%0d v=%0d got %b want %b", eh, ev, ls_a, wrapped_l);
            else pass_cnt++;
            total_cnt++;
        end
        if (ls_seen !== 2) $display("FAIL line_start_count got %0d want 2", ls_seen);
        else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_frame_timing();
        int vs_low = 0;
        int fs_seen = 0;
        int n = (8 - ev) * 800 - eh;
        for (int i = 0; i < n; i++) begin
            tick_a(1'b1);
            if (!vsync_a) vs_low++;
            if (fs_a) fs_seen++;
            if (vsync_a !== (Align ? vs_a(pv) : vs_a(ev)))
                $display("FAIL frame_vsync at v=%0d h=%0d got %b want %b", ev, eh, vsync_a, ~vsync_a);
            else pass_cnt++;
            total_cnt++;
            if (fs_a !== wrapped_f)
                $display("FAIL frame_start at v=%0d h=%0d got %b want %b", ev, eh, fs_a, wrapped_f);
            else pass_cnt++;
            total_cnt++;
        end
        if (vs_low !== 1600) $display("FAIL vsync_low_clks got %0d want 1600", vs_low);
        else pass_cnt++;
        total_cnt++;
        if (fs_seen !== 1) $display("FAIL frame_start_count got %0d want 1", fs_seen);
        else pass_cnt++;
        total_cnt++;
        if (fc_a !== 8'd1) $display("FAIL frame_count_first got %0d want 1", fc_a);
        else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_en_gating();
        logic [7:0] pattern = 8'b0101_0101;
        for (int i = 0; i < 10000 && !(eh == 797 && ev == 7); i++) tick_a(1'b1);
        if ({hpos_a, vpos_a} !== {10'd797, 10'd7})
            $display("FAIL gate_approach got %0d,%0d want 797,7", hpos_a, vpos_a);
        else pass_cnt++;
        total_cnt++;
        for (int i = 0; i < 8; i++) begin
            tick_a(pattern[i]);
            if ({hpos_a, vpos_a, fc_a} !== {10'(eh), 10'(ev), 8'(efc)})
                $display("FAIL gate_pos step %0d got %0d,%0d,%0d want %0d,%0d,%0d",
                         i, hpos_a, vpos_a, fc_a, eh, ev, efc);
            else pass_cnt++;
            total_cnt++;
            if ({ls_a, fs_a} !== {wrapped_l, wrapped_f})
                $display("FAIL gate_pulses step %0d got %b%b want %b%b", i, ls_a, fs_a,
                         wrapped_l, wrapped_f);
            else pass_cnt++;
            total_cnt++;
            if ({hsync_a, vsync_a, disp_a} !== (Align ? {hs_a(ph), vs_a(pv), dp_a(ph, pv)}
                                                      : {hs_a(eh), vs_a(ev), dp_a(eh, ev)}))
                $display("FAIL gate_levels step %0d got %b%b%b", i, hsync_a, vsync_a, disp_a);
            else pass_cnt++;
            total_cnt++;
        end
        if ({hpos_a, vpos_a, fc_a} !== {10'd1, 10'd0, 8'd2})
            $display("FAIL gate_final got %0d,%0d,%0d want 1,0,2", hpos_a, vpos_a, fc_a);
        else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10000 && !(eh == 300 && ev == 2); i++) tick_a(1'b1);
        if ({hpos_a, vpos_a, fc_a} !== {10'd300, 10'd2, 8'd2})
            $display("FAIL mid_approach got %0d,%0d,%0d want 300,2,2", hpos_a, vpos_a, fc_a);
        else pass_cnt++;
        total_cnt++;
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        if ({hpos_a, vpos_a, fc_a} !== 28'd0)
            $display("FAIL mid_reset_pos got %0d,%0d,%0d want 0,0,0", hpos_a, vpos_a, fc_a);
        else pass_cnt++;
        total_cnt++;
        if ({ls_a, fs_a, hsync_a, vsync_a, disp_a} !== 5'b00111)
            $display("FAIL mid_reset_flags got %b%b%b%b%b want 00111", ls_a, fs_a, hsync_a,
                     vsync_a, disp_a);
        else pass_cnt++;
        total_cnt++;
        rst_a = 1'b0;
        tick_a(1'b1);
        if ({hpos_a, fs_a} !== {10'd1, 1'b0})
            $display("FAIL mid_restart got h=%0d fs=%b want h=1 fs=0", hpos_a, fs_a);
        else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_small_align();
        // Bit k holds the value expected after en-step k+1 from reset (h = 1..6, 0).
        logic [6:0] hs_vec = Align ? 7'b1011111 : 7'b1101111;
        logic [6:0] de_vec = Align ? 7'b0001111 : 7'b1000111;
        rst_b = 1'b0;
        en_b = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            if (hpos_b !== 10'((k + 1) % 7)) $display("FAIL small_hpos got %0d want %0d", hpos_b, (k + 1) % 7);
            else pass_cnt++;
            total_cnt++;
            if (hsync_b !== hs_vec[k]) $display("FAIL small_hsync step %0d got %b want %b", k, hsync_b, hs_vec[k]);
            else pass_cnt++;
            total_cnt++;
            if (disp_b !== de_vec[k]) $display("FAIL small_display step %0d got %b want %b", k, disp_b, de_vec[k]);
            else pass_cnt++;
            total_cnt++;
        end
    endtask

    task automatic test_small_frame_wrap();
        int fs_seen = 0;
        for (int i = 0; i < 256 * 42 + 20 && fs_seen < 256; i++) begin
            @(posedge clk);
            #1;
            if (fs_b) begin
                fs_seen++;
                if ({hpos_b, vpos_b, fc_b} !== {10'd0, 10'd0, 8'(fs_seen % 256)})
                    $display("FAIL small_frame %0d got %0d,%0d,%0d want 0,0,%0d", fs_seen,
                             hpos_b, vpos_b, fc_b, fs_seen % 256);
                else pass_cnt++;
                total_cnt++;
            end
        end
        if (fs_seen !== 256) $display("FAIL small_frame_budget got %0d frames want 256", fs_seen);
        else pass_cnt++;
        total_cnt++;
        if (fc_b !== 8'd0) $display("FAIL small_fc_wrap got %0d want 0", fc_b);
        else pass_cnt++;
        total_cnt++;
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_en_gating();
        test_reset_mid();
        test_small_align();
        test_small_frame_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Upstream timing source for the VGA pattern and dither path.
- Produces hsync/vsync, visible-area flag, pixel coordinates, line/frame boundary pulses and a frame counter.
- Downstream consumers are the RGB pattern generator and the RGB222 temporal-dither stage; the latter uses frame_start to re-seed its threshold sequence.
- Default timing is 640x480@60 with a 25.175 MHz pixel clock.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, hsync active level (0 = active-low)
- VSYNC_POL, 0, vsync active level (0 = active-low)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- en  in  1  pixel-advance enable; counters step only when high
- hpos  out  10  horizontal counter, 0..H_TOTAL-1
- vpos  out  10  vertical counter, 0..V_TOTAL-1
- hsync  out  1  horizontal sync at HSYNC_POL
- vsync  out  1  vertical sync at VSYNC_POL
- display_on  out  1  high inside the visible area
- line_start  out  1  one-clk pulse when hpos wraps to 0
- frame_start  out  1  one-clk pulse when (hpos,vpos) wraps to (0,0)
- frame_count  out  8  frames completed, wraps 255->0

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high. No asynchronous paths.
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800)
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525)
  - Both must be ≤1024; elaboration error otherwise.
- Reset (rst high at a clk edge), values held while rst stays high:
  - hpos=0, vpos=0, frame_count=0
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL
  - display_on=1 (matches the (0,0) decode)
  - line_start=0, frame_start=0
- Counter stepping, on a clk edge with en=1:
  - hpos<H_TOTAL-1: hpos+=1.
  - hpos==H_TOTAL-1: hpos=0, line_start=1, vpos steps.
  - vpos step: vpos+=1, or if vpos==V_TOTAL-1 then vpos=0, frame_start=1, frame_count+=1 (mod 256).
  - frame_start and line_start are both asserted on the same clk at a frame wrap.
- en=0: counters and level outputs hold; line_start and frame_start forced 0 that cycle. Pulses never last more than one clk.
- Registered outputs, zero latency: every output is a flop, updated in the same edge as hpos/vpos, and always equals the decode of the current hpos/vpos.
- Decode:
  - display_on = (hpos<H_DISPLAY) && (vpos<V_DISPLAY)
  - hsync active iff H_DISPLAY+H_FRONT ≤ hpos < H_DISPLAY+H_FRONT+H_SYNC, i.e. 656..751
  - vsync active iff V_DISPLAY+V_FRONT ≤ vpos < V_DISPLAY+V_FRONT+V_SYNC, i.e. 490..491
  - vsync changes only at the hpos wrap edge, together with vpos.
- Reset mid-frame: restarts at (0,0) on the next edge. No frame_start pulse is generated by reset itself.
- rst has priority over en.
- Arithmetic is unsigned. No counter can exceed its TOTAL-1, so there are no out-of-range states.

Optional Feature:
- Macro: VGA_SYNC_GEN_ALIGN_EN
- Defined: hsync, vsync and display_on pass through one extra register stage (also gated by en; reset to the inactive/reset values above). They lag hpos/vpos by exactly one en-step, aligning with one registered RGB stage downstream.
- Undefined: zero-lag decode as specified in Behaviour.
- hpos, vpos, line_start, frame_start and frame_count are unaffected in both cases.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing localparams for 640x480@60
  - H_TOTAL/V_TOTAL helper functions
  - a typedef for the 10-bit coordinate
- One natural sub-module: vga_axis_counter, instantiated twice (horizontal, vertical).
  - Inputs: step.
  - Outputs: count, wrap, sync window, display window.
  - Parameterised by DISPLAY/FRONT/SYNC/BACK/POL.

Test Plan:
- Reset: assert rst 3 clks with en=1 -> hpos=0, vpos=0, hsync=1, vsync=1, display_on=1, pulses 0, frame_count=0.
- Line timing, en=1 from reset: hsync falls when hpos=656 and rises at hpos=752; display_on falls at hpos=640. line_start high exactly once per 800 clks, at hpos=0, vpos=1.
- Frame timing: vsync low for vpos 490..491 (1600 clks). frame_start high once after 420000 clks; frame_count 0->1, and 255->0 after 256 frames (run with small parameters).
- en gating: en toggled 1,0,1,0 -> hpos advances every other clk. A wrap falling on an en=0 cycle is deferred, with its pulse issued one clk later on the en=1 cycle.
- Reset mid-frame at hpos=300, vpos=200 -> next edge hpos=0, vpos=0, no frame_start, frame_count=0.
- Small config (H 4/1/1/1, V 3/1/1/1) with VGA_SYNC_GEN_ALIGN_EN defined/undefined -> hsync/display_on lag hpos decode by exactly one en-step only when defined.
